// File: rtl/ysyx_24090018_alu_pkg.sv
// Shared constants and the decoded-operation record for the ALU issue stage.
package ysyx_24090018_alu_pkg;

   localparam int XLEN  = 32;
   localparam int SEL_W = 4;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_ALT = 7'h20;

   typedef struct packed {
      logic [XLEN-1:0]  din1;
      logic [XLEN-1:0]  din2;
      logic [SEL_W-1:0] sel;
      logic [4:0]       rd;
      logic             wen;
      logic             illegal;
      logic [XLEN-1:0]  pc;
   } alu_op_t;

   localparam int OP_W = $bits(alu_op_t);

endpackage

// File: rtl/ysyx_24090018_alu_dec.sv
// Combinational decoder: RV32I ALU-class instruction plus operands -> ALU operation record.
module ysyx_24090018_alu_dec
   import ysyx_24090018_alu_pkg::*;
(
   input  logic [31:0] inst_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   output alu_op_t     op_o
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [3:0]  sel;
   logic        legal;

   assign opc   = inst_i[6:0];
   assign f3    = inst_i[14:12];
   assign f7    = inst_i[31:25];
   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_u = {inst_i[31:12], 12'b0};

   always_comb begin
      legal = 1'b1;
      sel   = ALU_ADD;
      d1    = '0;
      d2    = '0;
      case (opc)
         OPC_OP: begin
            d1 = rs1_i;
            d2 = rs2_i;
            case ({f7, f3})
               {7'h00, 3'b000}: sel = ALU_ADD;
               {F7_ALT, 3'b000}: sel = ALU_SUB;
               {7'h00, 3'b001}: sel = ALU_SLL;
               {7'h00, 3'b100}: sel = ALU_XOR;
               {7'h00, 3'b101}: sel = ALU_SRL;
               {F7_ALT, 3'b101}: sel = ALU_SRA;
               {7'h00, 3'b110}: sel = ALU_OR;
               {7'h00, 3'b111}: sel = ALU_AND;
               default:         legal = 1'b0;
            endcase
         end
         OPC_OPIMM: begin
            d1 = rs1_i;
            d2 = imm_i;
            case (f3)
               3'b000: sel = ALU_ADD;
               3'b100: sel = ALU_XOR;
               3'b110: sel = ALU_OR;
               3'b111: sel = ALU_AND;
               // Shifts take only the 5-bit shamt; the upper immediate bits select SRL/SRA.
               3'b001: begin
                  d2    = {27'b0, inst_i[24:20]};
                  sel   = ALU_SLL;
                  legal = (f7 == 7'h00);
               end
               3'b101: begin
                  d2    = {27'b0, inst_i[24:20]};
                  sel   = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  legal = (f7 == 7'h00) || (f7 == F7_ALT);
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            d1 = '0;
            d2 = imm_u;
         end
         OPC_AUIPC: begin
            d1 = pc_i;
            d2 = imm_u;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      op_o         = '0;
      op_o.pc      = pc_i;
      op_o.rd      = inst_i[11:7];
      op_o.illegal = !legal;
      if (legal) begin
         op_o.din1 = d1;
         op_o.din2 = d2;
         op_o.sel  = sel;
         op_o.wen  = (inst_i[11:7] != 5'd0);
      end
   end

endmodule

// File: rtl/ysyx_24090018_alu_issue.sv
// ALU operand issue stage: decodes on accept, registers the result, 1-entry skid behind it.
// Handshake: a side transfers on a rising edge where its valid and ready are both high.
module ysyx_24090018_alu_issue
   import ysyx_24090018_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_inst_i,
   input  logic [31:0] in_pc_i,
   input  logic [31:0] in_rs1_i,
   input  logic [31:0] in_rs2_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_din1_o,
   output logic [31:0] out_din2_o,
   output logic [3:0]  out_sel_o,
   output logic [4:0]  out_rd_o,
   output logic        out_wen_o,
   output logic        out_illegal_o,
   output logic [31:0] out_pc_o
);

   alu_op_t dec_op;
   alu_op_t out_q, out_d;
   alu_op_t skid_q, skid_d;
   logic    out_valid_q, out_valid_d;
   logic    skid_valid_q, skid_valid_d;
   logic    in_ready_q, in_ready_d;
   logic    accept;
   logic    hold;

   ysyx_24090018_alu_dec u_dec (
      .inst_i (in_inst_i),
      .pc_i   (in_pc_i),
      .rs1_i  (in_rs1_i),
      .rs2_i  (in_rs2_i),
      .op_o   (dec_op)
   );

   assign accept = in_valid_i && in_ready_q;
   assign hold   = out_valid_q && !out_ready_i;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (hold) begin
         if (accept) begin
            skid_d       = dec_op;
            skid_valid_d = 1'b1;
         end
      end else if (skid_valid_q) begin
         // in_ready was low, so no new entry can compete with the skid this cycle.
         out_d        = skid_q;
         out_valid_d  = 1'b1;
         skid_valid_d = 1'b0;
      end else if (accept) begin
         out_d       = dec_op;
         out_valid_d = 1'b1;
      end else begin
         out_valid_d = 1'b0;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = out_valid_q;
   assign out_din1_o    = out_q.din1;
   assign out_din2_o    = out_q.din2;
   assign out_sel_o     = out_q.sel;
   assign out_rd_o      = out_q.rd;
   assign out_wen_o     = out_q.wen;
   assign out_illegal_o = out_q.illegal;
   assign out_pc_o      = out_q.pc;

endmodule

// File: tb/tb_ysyx_24090018_alu_issue.sv
// Directed bench for the ALU issue stage: decode vectors, skid ordering, flush, async reset.
module tb_ysyx_24090018_alu_issue;

   localparam int W  = 107;
   localparam int NV = 15;

   logic        clk;
   logic        rst_n;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_inst_i;
   logic [31:0] in_pc_i;
   logic [31:0] in_rs1_i;
   logic [31:0] in_rs2_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_din1_o;
   logic [31:0] out_din2_o;
   logic [3:0]  out_sel_o;
   logic [4:0]  out_rd_o;
   logic        out_wen_o;
   logic        out_illegal_o;
   logic [31:0] out_pc_o;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   // Hand-decoded vector table: inst, pc, rs1, rs2 -> din1, din2, sel, rd, wen, illegal.
   logic [31:0] v_inst [NV] = '{32'h002081B3, 32'h40208233, 32'h00209333, 32'h0020D333,
                                32'h0020E333, 32'h7FF0C113, 32'hFF00F113, 32'hABCDE3B7,
                                32'h12345097, 32'h0020A1B3, 32'h022081B3, 32'h00000013,
                                32'h40309293, 32'h0020F333, 32'h4020D333};
   logic [31:0] v_rs1  [NV] = '{32'h5, 32'h10, 32'h1, 32'hF0, 32'hA, 32'h123, 32'hFF, 32'h55,
                                32'h66, 32'h1, 32'h1, 32'h9, 32'h8, 32'hC, 32'h80000000};
   logic [31:0] v_rs2  [NV] = '{32'h7, 32'h3, 32'h4, 32'h2, 32'h5, 32'hDEAD, 32'h0, 32'h77,
                                32'h88, 32'h2, 32'h2, 32'h0, 32'h0, 32'hA, 32'h4};
   logic [31:0] v_d1   [NV] = '{32'h5, 32'h10, 32'h1, 32'hF0, 32'hA, 32'h123, 32'hFF, 32'h0,
                                32'h80000000, 32'h0, 32'h0, 32'h9, 32'h0, 32'hC, 32'h80000000};
   logic [31:0] v_d2   [NV] = '{32'h7, 32'h3, 32'h4, 32'h2, 32'h5, 32'h7FF, 32'hFFFFFFF0,
                                32'hABCDE000, 32'h12345000, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'hA, 32'h4};
   logic [3:0]  v_sel  [NV] = '{4'h2, 4'h6, 4'h4, 4'h5, 4'h1, 4'h3, 4'h0, 4'h2, 4'h2,
                                4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h7};
   logic [4:0]  v_rd   [NV] = '{5'd3, 5'd4, 5'd6, 5'd6, 5'd6, 5'd2, 5'd2, 5'd7, 5'd1,
                                5'd3, 5'd3, 5'd0, 5'd5, 5'd6, 5'd6};
   logic        v_wen  [NV] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
   logic        v_ill  [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0};

   ysyx_24090018_alu_issue dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .in_inst_i     (in_inst_i),
      .in_pc_i       (in_pc_i),
      .in_rs1_i      (in_rs1_i),
      .in_rs2_i      (in_rs2_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_din1_o    (out_din1_o),
      .out_din2_o    (out_din2_o),
      .out_sel_o     (out_sel_o),
      .out_rd_o      (out_rd_o),
      .out_wen_o     (out_wen_o),
      .out_illegal_o (out_illegal_o),
      .out_pc_o      (out_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid_i = 1'b1;
      in_inst_i  = inst;
      in_pc_i    = pc;
      in_rs1_i   = rs1;
      in_rs2_i   = rs2;
   endtask

   task automatic idle();
      in_valid_i = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [3:0] sel, input logic [4:0] rd, input logic wen,
                            input logic ill, input logic [31:0] pc);
      chk({tag, ".valid"}, W'(out_valid_o), W'(1'b1));
      chk({tag, ".din1"}, W'(out_din1_o), W'(d1));
      chk({tag, ".din2"}, W'(out_din2_o), W'(d2));
      chk({tag, ".sel"}, W'(out_sel_o), W'(sel));
      chk({tag, ".rd"}, W'(out_rd_o), W'(rd));
      chk({tag, ".wen"}, W'(out_wen_o), W'(wen));
      chk({tag, ".illegal"}, W'(out_illegal_o), W'(ill));
      chk({tag, ".pc"}, W'(out_pc_o), W'(pc));
   endtask

   task automatic fill_out_and_skid();
      out_ready_i = 1'b0;
      drive(32'h002081B3, 32'h200, 32'h1, 32'h2);
      tick();
      drive(32'h002081B3, 32'h204, 32'h3, 32'h4);
      tick();
      idle();
   endtask

   initial begin : main
      int sent;
      int got;
      int cyc;
      bit acc;
      rst_n       = 1'b0;
      flush_i     = 1'b0;
      out_ready_i = 1'b0;
      in_valid_i  = 1'b0;
      in_inst_i   = '0;
      in_pc_i     = '0;
      in_rs1_i    = '0;
      in_rs2_i    = '0;

      repeat (2) tick();
      chk("reset.out_valid", W'(out_valid_o), W'(1'b0));
      chk("reset.in_ready", W'(in_ready_o), W'(1'b1));
      chk("reset.din1", W'(out_din1_o), W'(32'h0));
      chk("reset.pc", W'(out_pc_o), W'(32'h0));
      rst_n = 1'b1;
      tick();

      // add x3,x1,x2 with one-cycle latency
      out_ready_i = 1'b1;
      drive(32'h002081B3, 32'h100, 32'd5, 32'd7);
      tick();
      idle();
      check_out("add", 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 32'h100);
      tick();
      chk("add.drained", W'(out_valid_o), W'(1'b0));

      // srai then addi back to back at full rate
      drive(32'h40335293, 32'h104, 32'h80000000, 32'h0);
      tick();
      drive(32'hFFF00093, 32'h108, 32'h11, 32'h0);
      check_out("srai", 32'h80000000, 32'd3, 4'b0111, 5'd5, 1'b1, 1'b0, 32'h104);
      tick();
      idle();
      check_out("addi", 32'h11, 32'hFFFFFFFF, 4'b0010, 5'd1, 1'b1, 1'b0, 32'h108);

      // auipc and slt
      drive(32'h12345097, 32'h80000000, 32'h0, 32'h0);
      tick();
      drive(32'h0020A1B3, 32'h80000004, 32'h1, 32'h2);
      check_out("auipc", 32'h80000000, 32'h12345000, 4'b0010, 5'd1, 1'b1, 1'b0, 32'h80000000);
      tick();
      idle();
      check_out("slt", 32'h0, 32'h0, 4'b0000, 5'd3, 1'b0, 1'b1, 32'h80000004);
      tick();

      // A,B,C against a stalled consumer
      out_ready_i = 1'b0;
      drive(32'h002081B3, 32'h300, 32'hA1, 32'h1);
      tick();
      drive(32'h002081B3, 32'h304, 32'hB2, 32'h2);
      chk("skid.a_ready", W'(in_ready_o), W'(1'b1));
      tick();
      drive(32'h002081B3, 32'h308, 32'hC3, 32'h3);
      check_out("skid.a_held1", 32'hA1, 32'h1, 4'b0010, 5'd3, 1'b1, 1'b0, 32'h300);
      chk("skid.full_ready", W'(in_ready_o), W'(1'b0));
      tick();
      check_out("skid.a_held2", 32'hA1, 32'h1, 4'b0010, 5'd3, 1'b1, 1'b0, 32'h300);
      chk("skid.c_blocked", W'(in_ready_o), W'(1'b0));
      tick();
      chk("skid.a_held3", W'(out_din1_o), W'(32'hA1));
      out_ready_i = 1'b1;
      tick();
      check_out("skid.b_out", 32'hB2, 32'h2, 4'b0010, 5'd3, 1'b1, 1'b0, 32'h304);
      chk("skid.ready_back", W'(in_ready_o), W'(1'b1));
      tick();
      idle();
      check_out("skid.c_out", 32'hC3, 32'h3, 4'b0010, 5'd3, 1'b1, 1'b0, 32'h308);
      tick();
      chk("skid.empty", W'(out_valid_o), W'(1'b0));

      // flush with output and skid occupied
      fill_out_and_skid();
      chk("flush.pre_ready", W'(in_ready_o), W'(1'b0));
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush.out_valid", W'(out_valid_o), W'(1'b0));
      chk("flush.in_ready", W'(in_ready_o), W'(1'b1));
      // flush discards a same-cycle accept
      out_ready_i = 1'b1;
      flush_i = 1'b1;
      drive(32'h002081B3, 32'h400, 32'h1, 32'h1);
      tick();
      flush_i = 1'b0;
      idle();
      chk("flush.accept_dropped", W'(out_valid_o), W'(1'b0));
      tick();
      chk("flush.still_empty", W'(out_valid_o), W'(1'b0));

      // async reset in the middle of a stall
      fill_out_and_skid();
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset.out_valid", W'(out_valid_o), W'(1'b0));
      chk("areset.in_ready", W'(in_ready_o), W'(1'b1));
      chk("areset.din1", W'(out_din1_o), W'(32'h0));
      chk("areset.sel_rd", W'({out_sel_o, out_rd_o, out_wen_o}), W'(10'h0));
      tick();
      rst_n = 1'b1;
      tick();

      // vector stream with a randomly stalling consumer
      sent = 0;
      got  = 0;
      cyc  = 0;
      while ((sent < NV || exp_q.size() > 0) && cyc < 2000) begin
         acc = 1'b0;
         out_ready_i = 1'($urandom_range(0, 1));
         if (sent < NV && $urandom_range(0, 3) != 0)
            drive(v_inst[sent], 32'h1000 + 32'(sent * 4), v_rs1[sent], v_rs2[sent]);
         else
            idle();
         if (sent == 8) in_pc_i = 32'h80000000;
         @(negedge clk);
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("stream.unexpected", W'(out_valid_o), W'(1'b0));
            end else begin
               chk($sformatf("stream.item%0d", got),
                   {out_din1_o, out_din2_o, out_sel_o, out_rd_o, out_wen_o, out_illegal_o, out_pc_o},
                   exp_q.pop_front());
            end
            got++;
         end
         if (in_valid_i && in_ready_o) begin
            exp_q.push_back({v_d1[sent], v_d2[sent], v_sel[sent], v_rd[sent], v_wen[sent],
                             v_ill[sent], (sent == 8) ? 32'h80000000 : 32'h1000 + 32'(sent * 4)});
            acc = 1'b1;
         end
         tick();
         if (acc) sent++;
         cyc++;
      end
      idle();
      chk("stream.all_sent", W'(sent), W'(NV));
      chk("stream.count", W'(got), W'(NV));
      chk("stream.queue_empty", W'(exp_q.size()), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
